// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   XLEN     : datapath width (32)
//   NOP_INSN : addi x0,x0,0, returned on fetch errors and after reset
//   state_e  : fetch FSM states
//   is_misaligned : true when a pc is not word-aligned
package ifetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory bus: single-outstanding req/gnt with a separate
// rvalid/rdata response phase.
//   req/addr    : request and word-aligned address (master -> slave)
//   gnt         : request accepted this cycle      (slave -> master)
//   rvalid/rdata: read response                    (slave -> master)
interface ifetch_if;
  import ifetch_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/ifetch_timer.sv
// 8-bit saturating cycle counter with clear, enable and terminal count.
//   clk_i/rst_i : clock, synchronous active-high reset
//   clr_i       : force count to zero (wins over en_i)
//   en_i        : count up one per cycle, saturating at 255
//   tc_o        : count equals TIMEOUT-1
module ifetch_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: takes fetch_pc from the core, performs one
// read on the imem bus and hands the instruction back via valid/ready.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   fetch_req_i/fetch_pc_i: fetch request and address
//   flush_i               : redirect, abandons the current fetch
//   inst_ready_i          : core consumes the held instruction
//   inst_valid_o, inst_o, inst_pc_o, inst_err_o : fetch result
//   imem                  : instruction memory bus (master side)
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned     TIMEOUT = 16,
  parameter logic [XLEN-1:0] NOP     = NOP_INSN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_req_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic            flush_i,
  input  logic            inst_ready_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_err_o,
  ifetch_if.master        imem
);

  state_e          state_q;
  logic            inst_valid_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            inst_err_q;
  logic            imem_req_q;
  logic [XLEN-1:0] imem_addr_q;
  // a timed-out response is still outstanding; HOLD must exit via DRAIN
  logic            drain_pend_q;

  logic accept_s;
  logic timer_clr_s;
  logic timer_en_s;
  logic timer_tc_s;

  // fetch acceptance and timer control
  always_comb begin
    accept_s = fetch_req_i && !flush_i &&
               ((state_q == ST_IDLE) ||
                ((state_q == ST_HOLD) && inst_ready_i && !drain_pend_q));
    // the timer restarts at gnt (WAIT) and on every entry to DRAIN
    timer_clr_s = (state_q == ST_REQ) || (state_q == ST_HOLD) ||
                  ((state_q == ST_WAIT) && flush_i);
    timer_en_s  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  end

  ifetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (timer_clr_s),
    .en_i  (timer_en_s),
    .tc_o  (timer_tc_s)
  );

  // fetch FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP;
      inst_pc_q    <= '0;
      inst_err_q   <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      drain_pend_q <= 1'b0;
    end else if (accept_s) begin
      inst_pc_q <= fetch_pc_i;
      if (is_misaligned(fetch_pc_i)) begin
        state_q      <= ST_HOLD;
        inst_valid_q <= 1'b1;
        inst_err_q   <= 1'b1;
        inst_q       <= NOP;
      end else begin
        state_q      <= ST_REQ;
        inst_valid_q <= 1'b0;
        inst_err_q   <= 1'b0;
        imem_req_q   <= 1'b1;
        imem_addr_q  <= fetch_pc_i;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_REQ: begin
          if (flush_i) begin
            imem_req_q <= 1'b0;
            // a grant in the flush cycle leaves a response in flight
            state_q    <= imem.gnt ? ST_DRAIN : ST_IDLE;
          end else if (imem.gnt) begin
            imem_req_q <= 1'b0;
            state_q    <= ST_WAIT;
          end else begin
            state_q    <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            state_q <= imem.rvalid ? ST_IDLE : ST_DRAIN;
          end else if (imem.rvalid) begin
            state_q      <= ST_HOLD;
            inst_valid_q <= 1'b1;
            inst_q       <= imem.rdata;
            inst_err_q   <= 1'b0;
          end else if (timer_tc_s) begin
            state_q      <= ST_HOLD;
            inst_valid_q <= 1'b1;
            inst_q       <= NOP;
            inst_err_q   <= 1'b1;
            drain_pend_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (flush_i || inst_ready_i) begin
            inst_valid_q <= 1'b0;
            drain_pend_q <= 1'b0;
            state_q      <= drain_pend_q ? ST_DRAIN : ST_IDLE;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (imem.rvalid || timer_tc_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          inst_valid_q <= 1'b0;
          imem_req_q   <= 1'b0;
          drain_pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_err_o   = inst_err_q;
  assign imem.req     = imem_req_q;
  assign imem.addr    = imem_addr_q;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  int n_cmp = 0;
  int n_err = 0;

  ifetch_if imem();

  ifetch #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fetch_req_i  (fetch_req),
    .fetch_pc_i   (fetch_pc),
    .flush_i      (flush),
    .inst_ready_i (inst_ready),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_err_o   (inst_err),
    .imem         (imem)
  );

  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_err"},   {31'd0, inst_err},   32'd0);
    chk({tag, "_req"},   {31'd0, imem.req},   32'd0);
    chk({tag, "_inst"},  inst,                32'h0000_0013);
    chk({tag, "_pc"},    inst_pc,             32'd0);
    chk({tag, "_addr"},  imem.addr,           32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_pc = 32'd0; flush = 1'b0; inst_ready = 1'b0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'd0;
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // basic fetch: accept cycle 0, req 1 with gnt, rvalid 2, inst_valid 3
    fetch_req = 1'b1; fetch_pc = 32'h8000_0000;
    tick();
    fetch_req = 1'b0;
    chk("basic_req",  {31'd0, imem.req}, 32'd1);
    chk("basic_addr", imem.addr, 32'h8000_0000);
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0;
    chk("basic_req_drop", {31'd0, imem.req}, 32'd0);
    chk("basic_novalid",  {31'd0, inst_valid}, 32'd0);
    imem.rvalid = 1'b1; imem.rdata = 32'h0050_0093;
    tick();
    imem.rvalid = 1'b0;
    chk("basic_valid", {31'd0, inst_valid}, 32'd1);
    chk("basic_inst",  inst, 32'h0050_0093);
    chk("basic_pc",    inst_pc, 32'h8000_0000);
    chk("basic_err",   {31'd0, inst_err}, 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("basic_idle", {31'd0, inst_valid}, 32'd0);

    // gnt delayed 3 cycles, inst_ready low 4 cycles, back-to-back fetch
    fetch_req = 1'b1; fetch_pc = 32'h8000_0004;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req",  {31'd0, imem.req}, 32'd1);
      chk("stall_addr", imem.addr, 32'h8000_0004);
      tick();
    end
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0;
    imem.rvalid = 1'b1; imem.rdata = 32'h00A0_0113;
    tick();
    imem.rvalid = 1'b0; imem.rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_inst",  inst, 32'h00A0_0113);
      chk("hold_pc",    inst_pc, 32'h8000_0004);
      tick();
    end
    inst_ready = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h8000_0008;
    tick();
    inst_ready = 1'b0; fetch_req = 1'b0;
    chk("b2b_valid_drop", {31'd0, inst_valid}, 32'd0);
    chk("b2b_req",        {31'd0, imem.req}, 32'd1);
    chk("b2b_addr",       imem.addr, 32'h8000_0008);
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h0000_0033;
    tick();
    imem.rvalid = 1'b0;
    chk("b2b_inst", inst, 32'h0000_0033);
    chk("b2b_pc",   inst_pc, 32'h8000_0008);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // flush one cycle after gnt; rvalid two cycles later is drained
    fetch_req = 1'b1; fetch_pc = 32'h8000_000C;
    tick();
    fetch_req = 1'b0; imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushw_valid1", {31'd0, inst_valid}, 32'd0);
    chk("flushw_req1",   {31'd0, imem.req}, 32'd0);
    tick();
    imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    chk("flushw_valid2", {31'd0, inst_valid}, 32'd0);
    tick();
    imem.rvalid = 1'b0;
    chk("flushw_valid3", {31'd0, inst_valid}, 32'd0);
    fetch_req = 1'b1; fetch_pc = 32'h8000_0010;
    tick();
    fetch_req = 1'b0;
    chk("flushw_newreq",  {31'd0, imem.req}, 32'd1);
    chk("flushw_newaddr", imem.addr, 32'h8000_0010);
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h0010_8093;
    tick();
    imem.rvalid = 1'b0;
    chk("flushw_inst",  inst, 32'h0010_8093);
    chk("flushw_pc",    inst_pc, 32'h8000_0010);
    chk("flushw_valid", {31'd0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // misaligned pc: error result next cycle with no bus access
    fetch_req = 1'b1; fetch_pc = 32'h8000_0002;
    tick();
    fetch_req = 1'b0;
    chk("mis_req",   {31'd0, imem.req}, 32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd1);
    chk("mis_err",   {31'd0, inst_err}, 32'd1);
    chk("mis_inst",  inst, 32'h0000_0013);
    chk("mis_pc",    inst_pc, 32'h8000_0002);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("mis_idle", {31'd0, inst_valid}, 32'd0);

    // timeout: WAIT holds timer 0..3 over 4 cycles after the gnt edge, HOLD follows
    fetch_req = 1'b1; fetch_pc = 32'h8000_0014;
    tick();
    fetch_req = 1'b0; imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_valid", {31'd0, inst_valid}, 32'd0);
      tick();
    end
    chk("to_valid", {31'd0, inst_valid}, 32'd1);
    chk("to_err",   {31'd0, inst_err}, 32'd1);
    chk("to_inst",  inst, 32'h0000_0013);
    chk("to_pc",    inst_pc, 32'h8000_0014);
    inst_ready = 1'b1;
    tick();
    // now in DRAIN: a pending fetch must not issue a request
    inst_ready = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'h8000_0018;
    imem.rvalid = 1'b1; imem.rdata = 32'hBAD0_BAD0;
    chk("drain_valid", {31'd0, inst_valid}, 32'd0);
    chk("drain_req",   {31'd0, imem.req}, 32'd0);
    tick();
    imem.rvalid = 1'b0;
    chk("drain_exit_valid", {31'd0, inst_valid}, 32'd0);
    chk("drain_exit_req",   {31'd0, imem.req}, 32'd0);
    tick();
    fetch_req = 1'b0;
    chk("post_drain_req",  {31'd0, imem.req}, 32'd1);
    chk("post_drain_addr", imem.addr, 32'h8000_0018);
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h0020_8113;
    tick();
    imem.rvalid = 1'b0;
    chk("post_drain_inst", inst, 32'h0020_8113);
    chk("post_drain_err",  {31'd0, inst_err}, 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // flush in REQ without gnt withdraws; fetch in the flush cycle is refused
    fetch_req = 1'b1; fetch_pc = 32'h8000_0020;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushr_req", {31'd0, imem.req}, 32'd0);
    tick();
    fetch_req = 1'b0;
    chk("flushr_rereq",  {31'd0, imem.req}, 32'd1);
    chk("flushr_readdr", imem.addr, 32'h8000_0020);
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h0000_1111;
    tick();
    imem.rvalid = 1'b0;
    // flush in HOLD drops inst_valid next cycle
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushh_valid", {31'd0, inst_valid}, 32'd0);

    // reset one cycle after gnt; following rvalid ignored
    fetch_req = 1'b1; fetch_pc = 32'h8000_001C;
    tick();
    fetch_req = 1'b0; imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rstw");
    imem.rvalid = 1'b1; imem.rdata = 32'h1111_1111;
    tick();
    imem.rvalid = 1'b0;
    chk("rstw_valid1", {31'd0, inst_valid}, 32'd0);
    chk("rstw_req1",   {31'd0, imem.req}, 32'd0);
    tick();
    chk("rstw_valid2", {31'd0, inst_valid}, 32'd0);
    chk("rstw_inst",   inst, 32'h0000_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
